zet_event_seq: RTL

- Parametrised microcode sequencer with an NEV-channel event arbiter.
- Generalises the fixed trap/divide/NMI/IRQ redirection into a prioritised vector table.
- Adds per-channel masks, boundary vs. synchronous capture modes and a parametrised multi-cycle stall counter.
- Sits between the opcode decoder (base_addr) and the microcode ROM (seq_addr).

---
 rtl/zet_event_seq.sv | 124 ++++++++++++
 1 files changed

// File: rtl/zet_event_seq.sv
// zet_event_seq
// Microcode sequencer with a prioritised NEV-channel event arbiter. It sits
// between the opcode decoder, which supplies base_addr, and the microcode
// ROM, which is addressed by seq_addr.
//
// When an event channel is active, its vector replaces base_addr as the
// sequence origin. Each channel is either synchronous, meaning it can be
// captured in any exec cycle, or boundary-only, meaning it is captured only
// at end_seq. A fixed-length stall counter holds the sequence for
// multi-cycle instructions such as divide.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   base_addr   entry address from the opcode decoder
//   ev_req      level event requests, one bit per channel
//   ev_mask     channel enables, 1 = enabled
//   ev_vec      packed entry vectors; channel i is at [i*ADDR_W +: ADDR_W]
//   exec_st     microcode is executing
//   end_seq     last micro-instruction of the current sequence
//   block       bus stall; freezes everything except the stall counter
//   stall_req   current instruction needs a multi-cycle stall
//   seq_addr    microcode address (combinational)
//   ev_active   one-hot channel whose sequence is running
//   ev_ack      one-cycle acknowledge, the cycle after ev_active rises
//   stall_busy  stall counter is non-zero
module zet_event_seq #(
    parameter int                ADDR_W    = 9,
    parameter int                NEV       = 4,
    parameter logic [NEV-1:0]    SYNC_MASK = 4'b0010,
    parameter int                STALL_CYC = 18,
    parameter int                STALL_W   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [NEV-1:0]        ev_req,
    input  logic [NEV-1:0]        ev_mask,
    input  logic [NEV*ADDR_W-1:0] ev_vec,
    input  logic                  exec_st,
    input  logic                  end_seq,
    input  logic                  block,
    input  logic                  stall_req,
    output logic [ADDR_W-1:0]     seq_addr,
    output logic [NEV-1:0]        ev_active,
    output logic [NEV-1:0]        ev_ack,
    output logic                  stall_busy
);

    logic [ADDR_W-1:0]  seq;
    logic [STALL_W-1:0] stall_cnt;
    logic [NEV-1:0]     active_d;
    logic [NEV-1:0]     cand;
    logic [NEV-1:0]     win;
    logic [ADDR_W-1:0]  vec_sel;
    logic               arb_free;

    // The arbiter is free when idle, or when the running sequence ends this
    // cycle. The second case allows back-to-back events.
    assign arb_free = (ev_active == '0) | (end_seq & ~block);

    // Boundary channels additionally need end_seq in the same cycle.
    assign cand = ev_req & ev_mask & (SYNC_MASK | {NEV{end_seq}})
                & {NEV{exec_st & ~block & arb_free}};

    // Isolate the lowest set bit, so index 0 has the highest priority.
    assign win = cand & (~cand + NEV'(1));

    // Select the vector of the active channel. Because ev_active is one-hot,
    // ORing the masked vectors yields exactly one of them.
    always_comb begin
        vec_sel = '0;
        for (int i = 0; i < NEV; i++) begin
            if (ev_active[i]) begin
                vec_sel = vec_sel | ev_vec[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign seq_addr   = ((ev_active != '0) ? vec_sel : base_addr) + seq;
    assign stall_busy = (stall_cnt != '0);

    // The stall counter keeps running through block, so that a bus stall
    // never stretches a divide. The sequence and the event state are frozen
    // by block. The ack history is not frozen, so the ack still pulses
    // exactly once.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq       <= '0;
            stall_cnt <= '0;
            ev_active <= '0;
            ev_ack    <= '0;
            active_d  <= '0;
        end else begin
            if (stall_req & exec_st) begin
                stall_cnt <= (stall_cnt == '0) ? STALL_W'(STALL_CYC)
                                               : stall_cnt - STALL_W'(1);
            end else begin
                stall_cnt <= '0;
            end

            if (!block) begin
                if (end_seq) begin
                    seq <= '0;
                end else if (stall_cnt != '0) begin
                    seq <= seq;
                end else if (exec_st) begin
                    seq <= seq + ADDR_W'(1);
                end else begin
                    seq <= '0;
                end

                if (win != '0) begin
                    ev_active <= win;
                end else if (end_seq) begin
                    ev_active <= '0;
                end
            end

            ev_ack   <= ev_active & ~active_d;
            active_d <= ev_active;
        end
    end

endmodule
